// File: rtl/sort_seq_pkg.sv
// Shared types and sizing helpers for the sequential sorting controller.
package sort_seq_pkg;

  // Controller phases: fill the buffer, bubble-sort it in place, drain it.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_DEPTH = 4;

  // Index width for the default depth.
  localparam int IDX_W = $clog2(DEFAULT_DEPTH);

  // Worst-case number of SORT cycles for the default depth.
  localparam int MAX_CMP = DEFAULT_DEPTH * (DEFAULT_DEPTH - 1) / 2;

  // Index width for any depth >= 2.
  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sort_seq_ctrl_mag_cmp.sv
// Unsigned magnitude comparator; exactly one of lt/eq/gt is high.
module mag_cmp #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Pure combinational compare of two unsigned words.
  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequential sorting controller: loads DEPTH words, bubble-sorts them with a
// single shared comparator (one compare/swap per clock), then drains them
// smallest first over a valid/ready port.
module sort_seq_ctrl
  import sort_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
);

  localparam int AW = idx_width(DEPTH);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LAST_PASS = AW'(DEPTH - 2);

  state_t state_q, state_d;

  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    pass;
  logic [AW-1:0]    pair;
  logic             swapped;
  logic             done_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    pair_nxt;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_lt;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             keep;
  logic             sw_any;
  logic             wr_last;
  logic             rd_last;
  logic             pair_last;
  logic             pass_last;

  // Operand selection and end-of-range decodes for the current pair/pass.
  always_comb begin
    pair_nxt  = pair + 1'b1;
    cmp_a     = mem[pair];
    cmp_b     = mem[pair_nxt];
    // Equal or smaller keeps order, so equal words stay in load order.
    keep      = cmp_lt | cmp_eq;
    sw_any    = swapped | cmp_gt;
    wr_last   = (wr_idx == LAST_IDX);
    rd_last   = (rd_idx == LAST_IDX);
    // Pass p ends at pair DEPTH-2-p.
    pair_last = (pair == (LAST_PASS - pass));
    pass_last = (pass == LAST_PASS);
  end

  mag_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && wr_last) state_d = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (pair_last && (!sw_any || pass_last)) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = mem[rd_idx];
        if (out_ready && rd_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    done = done_q;
  end

  // Counters, swap flag, first-OUT pulse and the word buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      pass    <= '0;
      pair    <= '0;
      swapped <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: the buffer is reset too, so a reset discards any partial batch
      // and out_data reads a defined value in every state.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done_q <= (state_q == SORT) && (state_d == OUT);
      unique case (state_q)
        LOAD: begin
          if (in_valid && in_ready) begin
            mem[wr_idx] <= in_data;
            if (wr_last) begin
              wr_idx  <= '0;
              pass    <= '0;
              pair    <= '0;
              swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        SORT: begin
          mem[pair]     <= keep ? cmp_a : cmp_b;
          mem[pair_nxt] <= keep ? cmp_b : cmp_a;
          if (pair_last) begin
            pair    <= '0;
            swapped <= 1'b0;
            if (!sw_any || pass_last) pass <= '0;
            else                      pass <= pass + 1'b1;
          end else begin
            pair    <= pair_nxt;
            swapped <= sw_any;
          end
        end
        OUT: begin
          if (out_valid && out_ready) begin
            rd_idx <= rd_last ? '0 : rd_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Self-checking bench for sort_seq_ctrl (WIDTH=2, DEPTH=4).
module tb_sort_seq_ctrl;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;

  int checks;
  int failures;

  typedef logic [DEPTH-1:0][WIDTH-1:0] batch_t;

  typedef struct {
    batch_t words;
    batch_t sorted;
    int     cycles;
    int     hold;
    bit     junk;
  } vec_t;

  vec_t tbl [5];

  sort_seq_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic batch_t mk(input int a, input int b, input int c, input int d);
    batch_t w;
    w[0] = WIDTH'(a);
    w[1] = WIDTH'(b);
    w[2] = WIDTH'(c);
    w[3] = WIDTH'(d);
    return w;
  endfunction

  // Reference: sorted order by counting occurrences of each value.
  function automatic batch_t model_sort(input batch_t w);
    batch_t s;
    int     k = 0;
    for (int v = 0; v < (1 << WIDTH); v++)
      for (int i = 0; i < DEPTH; i++)
        if (int'(w[i]) == v) begin
          s[k] = WIDTH'(v);
          k++;
        end
    return s;
  endfunction

  // Reference: bubble-sort passes with swaps equal the largest number of
  // strictly larger words preceding any word; one more clean pass ends it,
  // capped at DEPTH-1 passes. Pass k costs DEPTH-1-k compares.
  function automatic int model_cycles(input batch_t w);
    int moves = 0;
    int passes;
    int cyc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) if (w[j] > w[i]) c++;
      if (c > moves) moves = c;
    end
    passes = moves + 1;
    if (passes > DEPTH - 1) passes = DEPTH - 1;
    for (int k = 0; k < passes; k++) cyc += DEPTH - 1 - k;
    return cyc;
  endfunction

  // Present DEPTH words at negedges; ends at the negedge of the 1st SORT cycle.
  task automatic load_words(input batch_t w);
    for (int i = 0; i < DEPTH; i++) begin
      check("in_ready_load", int'(in_ready), 1);
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Count SORT cycles, then drain with an optional out_ready stall.
  task automatic finish_batch(input batch_t exp_s, input int exp_cyc,
                              input int hold, input bit junk);
    int cnt = 0;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 2'd3;
    end
    while (busy && cnt <= sort_seq_pkg::MAX_CMP + 2) begin
      check("in_ready_sort", int'(in_ready), 0);
      check("done_sort", int'(done), 0);
      cnt++;
      @(negedge clk);
    end
    check("busy_cycles", cnt, exp_cyc);
    out_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), int'(exp_s[0]));
      check("hold_done", int'(done), (h == 0) ? 1 : 0);
      check("in_ready_out", int'(in_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("out_valid", int'(out_valid), 1);
      check("out_data", int'(out_data), int'(exp_s[i]));
      check("out_done", int'(done), (i == 0 && hold == 0) ? 1 : 0);
      check("busy_out", int'(busy), 0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    check("in_ready_after", int'(in_ready), 1);
    check("out_valid_after", int'(out_valid), 0);
  endtask

  initial begin
    batch_t w;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    tbl[0] = '{words: mk(3, 1, 2, 0), sorted: mk(0, 1, 2, 3), cycles: 6, hold: 0, junk: 1'b0};
    tbl[1] = '{words: mk(0, 1, 2, 3), sorted: mk(0, 1, 2, 3), cycles: 3, hold: 0, junk: 1'b0};
    tbl[2] = '{words: mk(2, 2, 1, 2), sorted: mk(1, 2, 2, 2), cycles: 6, hold: 0, junk: 1'b0};
    tbl[3] = '{words: mk(1, 0, 3, 2), sorted: mk(0, 1, 2, 3), cycles: 5, hold: 3, junk: 1'b0};
    tbl[4] = '{words: mk(3, 1, 2, 0), sorted: mk(0, 1, 2, 3), cycles: 6, hold: 0, junk: 1'b1};

    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      load_words(tbl[t].words);
      finish_batch(tbl[t].sorted, tbl[t].cycles, tbl[t].hold, tbl[t].junk);
    end

    // Reset during the 2nd SORT cycle, then a fresh batch.
    load_words(mk(3, 1, 2, 0));
    @(negedge clk);
    check("mid_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", int'(in_ready), 1);
    w = mk(2, 0, 1, 3);
    load_words(w);
    finish_batch(mk(0, 1, 2, 3), model_cycles(w), 0, 1'b0);

    // Randomized batches against the reference model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'($urandom_range(0, 3));
      load_words(w);
      finish_batch(model_sort(w), model_cycles(w), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
